dterm_hist: RTL and testbench
=============================

// Module: dterm_hist
// PURPOSE
//  Parametrised derivative term for the heading PID; successor to the fixed Dterm.
//  Differentiates err_sat against the sample DEPTH valid readings back, held in a shift history.
//  Saturates the difference, scales it by D_COEFF, and registers the result with a valid strobe.
//  Sits between the heading error saturator and the PID summer.
//  A longer DEPTH gives a smoother derivative on slow gyro updates.
// PARAMETERS
//  ERR_W    10  width of signed err_sat input
//  D_SAT_W   8  signed width the difference is saturated to
//  COEFF_W   5  width of unsigned D_COEFF
//  D_COEFF  14  derivative gain (5'h0E), unsigned, 0..2^COEFF_W-1
//  DEPTH     2  number of valid samples back used for difference, 1..16
// PORTS
//  clk       in   1                  system clock, posedge
//  rst_n     in   1                  asynchronous active-low reset
//  clr       in   1                  synchronous flush of history and output
//  hdng_vld  in   1                  new err_sat sample valid this cycle
//  err_sat   in   ERR_W              signed saturated heading error
//  D_term    out  D_SAT_W+COEFF_W    signed derivative term, registered
//  D_vld     out  1                  1-cycle pulse: D_term updated last edge
//  primed    out  1                  history holds DEPTH real samples
// BEHAVIOUR
//  - Reset (rst_n=0, async): history all 0, fill count 0, D_term=0, D_vld=0, primed=0.
//  - History: DEPTH entries of ERR_W bits, hist[0] newest, hist[DEPTH-1] oldest.
//    On accepted sample, shift: hist[0]<=err_sat, hist[i]<=hist[i-1].
//    Never shifts otherwise.
//  - Difference (combinational on accept): diff = err_sat - hist[DEPTH-1], sign-extended to ERR_W+1.
//    Unfilled entries are 0, so early samples differentiate against zero.
//  - Saturation: clamp diff to [-2^(D_SAT_W-1), 2^(D_SAT_W-1)-1] (8b: -128..127).
//  - Scale: D_term = sat_diff * signed({1'b0,D_COEFF}), truncated to D_SAT_W+COEFF_W bits.
//    Never overflows; no further clamp.
//  - Latency: D_term and D_vld update on the same posedge that accepts the sample (1 edge).
//  - hdng_vld=0: D_term holds its last value, D_vld=0, history and fill unchanged.
//  - Fill count: saturating counter 0..DEPTH, +1 per accepted sample.
//    primed = (fill==DEPTH), registered.
//  - clr=1: history<=0, fill<=0, D_term<=0, D_vld<=0, primed<=0.
//    clr and hdng_vld together: clr wins, sample discarded.
//  - Reset mid-operation: all state returns to reset values immediately.
//    First sample after release differentiates against 0.
//  - DEPTH=1 reproduces the legacy Dterm behaviour exactly.
// TESTING  (defaults unless stated)
//  1. Reset release; hdng_vld=1, err_sat=10'h0FF -> diff 255 sat 127;
//     D_term=13'd1778, D_vld=1, primed=0.
//  2. Second 10'h0FF -> oldest still 0 -> D_term=1778, primed=1.
//     Third 10'h0FF -> diff 0 -> D_term=0.
//  3. History 10'h1FF,10'h1FF then err_sat=10'h200 (-512) -> diff -1023 sat -128;
//     D_term=13'h1900 (-1792).
//  4. hdng_vld=0 for 5 cycles with err_sat toggling -> D_term held, D_vld=0;
//     next valid sample uses the pre-gap history.
//  5. clr with hdng_vld=1 after primed -> D_term=0, primed=0, sample dropped.
//     Next 10'h010 -> D_term=16*14=224.
//  6. DEPTH=1 build: 10'h3FF then 10'h0FF -> D_term=-14 then 127*14=1778.
//     Also: async rst_n pulse mid-stream clears all outputs without a clock edge.

Source files
------------

// File: rtl/dterm_hist.sv
// dterm_hist: derivative term for the heading PID.
// Takes the difference between err_sat and the accepted sample DEPTH readings
// back, clamps it to D_SAT_W bits, multiplies by D_COEFF, and registers the
// result together with a one-cycle valid strobe.
//
// Ports:
//   clk       system clock, posedge
//   rst_n     asynchronous active-low reset
//   clr       synchronous flush of history, fill count and outputs (beats hdng_vld)
//   hdng_vld  err_sat carries a new sample this cycle
//   err_sat   signed saturated heading error, ERR_W bits
//   D_term    signed derivative term, D_SAT_W+COEFF_W bits, registered
//   D_vld     one-cycle pulse: D_term was updated on the last edge
//   primed    history holds DEPTH real samples
module dterm_hist #(
  parameter int unsigned ERR_W   = 10,
  parameter int unsigned D_SAT_W = 8,
  parameter int unsigned COEFF_W = 5,
  parameter int unsigned D_COEFF = 14,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       hdng_vld,
  input  logic [ERR_W-1:0]           err_sat,
  output logic [D_SAT_W+COEFF_W-1:0] D_term,
  output logic                       D_vld,
  output logic                       primed
);

  localparam int unsigned OUT_W  = D_SAT_W + COEFF_W;
  localparam int unsigned DIFF_W = ERR_W + 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  localparam logic [FILL_W-1:0]        FILL_MAX = FILL_W'(DEPTH);
  localparam logic signed [DIFF_W-1:0] SAT_HI   = DIFF_W'((1 << (D_SAT_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] SAT_LO   = DIFF_W'(-(1 << (D_SAT_W - 1)));
  localparam logic [COEFF_W-1:0]       COEFF    = COEFF_W'(D_COEFF);

  logic [ERR_W-1:0]  hist_q [DEPTH];
  logic [ERR_W-1:0]  hist_d [DEPTH];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [OUT_W-1:0]  d_term_q, d_term_d;
  logic              d_vld_q, d_vld_d;
  logic              primed_q, primed_d;

  logic signed [DIFF_W-1:0]  diff;
  logic signed [D_SAT_W-1:0] sat_diff;
  logic        [OUT_W-1:0]   sat_ext;
  logic        [OUT_W-1:0]   coef_ext;
  logic        [OUT_W-1:0]   prod;

  // Difference against the oldest entry, clamp, and scale (truncated to OUT_W)
  always_comb begin
    diff = {err_sat[ERR_W-1], err_sat} - {hist_q[DEPTH-1][ERR_W-1], hist_q[DEPTH-1]};
    if (diff > SAT_HI) begin
      sat_diff = SAT_HI[D_SAT_W-1:0];
    end else if (diff < SAT_LO) begin
      sat_diff = SAT_LO[D_SAT_W-1:0];
    end else begin
      sat_diff = diff[D_SAT_W-1:0];
    end
    // Low OUT_W bits of a two's-complement product do not depend on signedness
    sat_ext  = {{COEFF_W{sat_diff[D_SAT_W-1]}}, sat_diff};
    coef_ext = {{D_SAT_W{1'b0}}, COEFF};
    prod     = sat_ext * coef_ext;
  end

  // Next-state: clr flushes, accepted sample shifts history and updates output
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    d_term_d = d_term_q;
    d_vld_d  = 1'b0;
    primed_d = primed_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      fill_d   = '0;
      d_term_d = '0;
      primed_d = 1'b0;
    end else if (hdng_vld) begin
      hist_d[0] = err_sat;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
      d_term_d = prod;
      d_vld_d  = 1'b1;
      primed_d = (fill_d == FILL_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_q   <= '0;
      d_term_q <= '0;
      d_vld_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      fill_q   <= fill_d;
      d_term_q <= d_term_d;
      d_vld_q  <= d_vld_d;
      primed_q <= primed_d;
    end
  end

  assign D_term = d_term_q;
  assign D_vld  = d_vld_q;
  assign primed = primed_q;

endmodule

// File: tb/tb_dterm_hist.sv
// Bench for dterm_hist: a DEPTH=2 and a DEPTH=1 instance share one stimulus
// stream; a queue-based model of accepted samples predicts both every cycle,
// and directed literal checks pin the model to hand-computed values.
module tb_dterm_hist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        hdng_vld = 1'b0;
  logic [9:0]  err_sat = '0;
  logic [12:0] d_term2, d_term1;
  logic        d_vld2, d_vld1, primed2, primed1;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dterm_hist #(.DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hdng_vld(hdng_vld), .err_sat(err_sat),
    .D_term(d_term2), .D_vld(d_vld2), .primed(primed2)
  );

  dterm_hist #(.DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .hdng_vld(hdng_vld), .err_sat(err_sat),
    .D_term(d_term1), .D_vld(d_vld1), .primed(primed1)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of accepted samples since last flush; output from plain arithmetic
  int q2[$];
  int q1[$];
  int e_d2 = 0, e_d1 = 0, e_v = 0, e_p2 = 0, e_p1 = 0;
  int smp;

  function automatic int oldest(input int q[$], input int d);
    if (q.size() >= d) return q[q.size() - d];
    return 0;
  endfunction

  function automatic int scaled(input int diff);
    int s;
    s = diff;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s * 14;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      q2.delete(); q1.delete();
      e_d2 = 0; e_d1 = 0; e_v = 0; e_p2 = 0; e_p1 = 0;
    end else if (hdng_vld) begin
      smp  = int'($signed(err_sat));
      e_d2 = scaled(smp - oldest(q2, 2));
      e_d1 = scaled(smp - oldest(q1, 1));
      q2.push_back(smp);
      q1.push_back(smp);
      e_v  = 1;
      e_p2 = (q2.size() >= 2) ? 1 : 0;
      e_p1 = (q1.size() >= 1) ? 1 : 0;
    end else begin
      e_v = 0;
    end
  end

  // Per-cycle comparison against the model, just after each edge
  always @(posedge clk) begin
    #1;
    check("m_dterm2",  int'($signed(d_term2)), e_d2);
    check("m_vld2",    int'(d_vld2), e_v);
    check("m_primed2", int'(primed2), e_p2);
    check("m_dterm1",  int'($signed(d_term1)), e_d1);
    check("m_vld1",    int'(d_vld1), e_v);
    check("m_primed1", int'(primed1), e_p1);
  end

  task automatic step(input logic v, input logic c, input logic [9:0] e);
    @(negedge clk);
    hdng_vld = v;
    clr      = c;
    err_sat  = e;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dterm", int'(d_term2), 0);
    check("rst_vld", int'(d_vld2), 0);
    check("rst_primed", int'(primed2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first sample against empty history
    step(1'b1, 1'b0, 10'h0FF);
    check("t1_dterm", int'(d_term2), 1778);
    check("t1_vld", int'(d_vld2), 1);
    check("t1_primed", int'(primed2), 0);

    // 2: second still sees zero; third sees itself
    step(1'b1, 1'b0, 10'h0FF);
    check("t2_dterm", int'(d_term2), 1778);
    check("t2_primed", int'(primed2), 1);
    step(1'b1, 1'b0, 10'h0FF);
    check("t2_zero", int'(d_term2), 0);

    // 3: negative clamp
    step(1'b1, 1'b0, 10'h1FF);
    step(1'b1, 1'b0, 10'h1FF);
    step(1'b1, 1'b0, 10'h200);
    check("t3_dterm_raw", int'(d_term2), 'h1900);

    // 4: idle gap with toggling input leaves everything in place
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? 10'h155 : 10'h2AA);
      check("t4_hold", int'(d_term2), 'h1900);
      check("t4_vld", int'(d_vld2), 0);
    end
    step(1'b1, 1'b0, 10'h1F0);
    check("t4_after_gap", int'($signed(d_term2)), -210);

    // 5: clr beats a valid sample
    step(1'b1, 1'b1, 10'h0FF);
    check("t5_clr_dterm", int'(d_term2), 0);
    check("t5_clr_primed", int'(primed2), 0);
    check("t5_clr_vld", int'(d_vld2), 0);
    step(1'b1, 1'b0, 10'h010);
    check("t5_next", int'(d_term2), 224);

    // 6: DEPTH=1 legacy behaviour
    step(1'b0, 1'b1, 10'h000);
    step(1'b1, 1'b0, 10'h3FF);
    check("t6_d1_neg", int'($signed(d_term1)), -14);
    check("t6_d1_primed", int'(primed1), 1);
    step(1'b1, 1'b0, 10'h0FF);
    check("t6_d1_pos", int'(d_term1), 1778);

    // Async reset mid-cycle clears outputs with no clock edge
    @(negedge clk);
    hdng_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dterm2", int'(d_term2), 0);
    check("ar_dterm1", int'(d_term1), 0);
    check("ar_primed2", int'(primed2), 0);
    check("ar_primed1", int'(primed1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 10'h0FF);
    check("ar_first", int'(d_term2), 1778);
    check("ar_first_primed", int'(primed2), 0);

    step(1'b0, 1'b0, 10'h000);
    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
